// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: per-FU result FIFOs, round-robin grant of up to N_WR heads per cycle
// into registered regfile write ports. Optional WB_DROP_ZERO_TAG_EN squashes tag-0 heads.
`ifndef N
`define N 2
`endif

module wb_write_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned N_WR   = `N,
  parameter int unsigned TAG_W  = 7,
  parameter int unsigned DATA_W = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic [N_WR-1:0]                write_en,
  output logic [N_WR-1:0][TAG_W-1:0]     write_idx,
  output logic [N_WR-1:0][DATA_W-1:0]    write_data
);

  localparam int unsigned FuW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = TAG_W + DATA_W;

`ifdef WB_DROP_ZERO_TAG_EN
  localparam bit DropZero = 1'b1;
`else
  localparam bit DropZero = 1'b0;
`endif

  logic [EntW-1:0]                 mem_q [NUM_FU][DEPTH];
  logic [NUM_FU-1:0][PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [NUM_FU-1:0][PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NUM_FU-1:0][CntW-1:0]     cnt_q, cnt_d;
  logic [FuW-1:0]                  rr_ptr_q, rr_ptr_d;

  logic [N_WR-1:0]                 write_en_q, write_en_d;
  logic [N_WR-1:0][TAG_W-1:0]      write_idx_q, write_idx_d;
  logic [N_WR-1:0][DATA_W-1:0]     write_data_q, write_data_d;

  logic [NUM_FU-1:0]               enq, deq;
  logic [NUM_FU-1:0][TAG_W-1:0]    head_tag;
  logic [NUM_FU-1:0][DATA_W-1:0]   head_data;

  logic [N_WR-1:0][FuW-1:0]        port_sel;
  logic [N_WR-1:0]                 port_vld;
  logic                            any_grant;
  logic [FuW-1:0]                  last_fu;
  logic [FuW-1:0]                  scan_fu;
  int                              n_grant;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [FuW-1:0] fu_inc(input logic [FuW-1:0] f);
    return (f == FuW'(NUM_FU - 1)) ? '0 : f + 1'b1;
  endfunction

  // Ready is a pure function of registered occupancy; no credit for a same-cycle dequeue.
  always_comb begin
    for (int i = 0; i < int'(NUM_FU); i++) begin
      fu_ready[i]                  = (cnt_q[i] < CntW'(DEPTH));
      enq[i]                       = fu_valid[i] && fu_ready[i];
      {head_tag[i], head_data[i]}  = mem_q[i][rd_ptr_q[i]];
    end
  end

  // Round-robin scan from rr_ptr; the k-th grant in scan order lands on write port k.
  always_comb begin
    deq       = '0;
    port_sel  = '0;
    port_vld  = '0;
    any_grant = 1'b0;
    last_fu   = rr_ptr_q;
    scan_fu   = '0;
    n_grant   = 0;
    for (int k = 0; k < int'(NUM_FU); k++) begin
      scan_fu = FuW'((int'(rr_ptr_q) + k) % int'(NUM_FU));
      if (cnt_q[scan_fu] != '0) begin
        if (DropZero && (head_tag[scan_fu] == '0)) begin
          deq[scan_fu] = 1'b1;
        end else if (n_grant < int'(N_WR)) begin
          deq[scan_fu] = 1'b1;
          for (int p = 0; p < int'(N_WR); p++) begin
            if (p == n_grant) begin
              port_sel[p] = scan_fu;
              port_vld[p] = 1'b1;
            end
          end
          n_grant   = n_grant + 1;
          last_fu   = scan_fu;
          any_grant = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (enq[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (deq[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      unique case ({enq[i], deq[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_comb begin
    write_en_d   = '0;
    write_idx_d  = '0;
    write_data_d = '0;
    rr_ptr_d     = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else begin
      for (int p = 0; p < int'(N_WR); p++) begin
        if (port_vld[p]) begin
          write_en_d[p]   = 1'b1;
          write_idx_d[p]  = head_tag[port_sel[p]];
          write_data_d[p] = head_data[port_sel[p]];
        end
      end
      if (any_grant) rr_ptr_d = fu_inc(last_fu);
    end
  end

  // Storage needs no reset: an entry is only read while its count is non-zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (enq[i] && !flush) mem_q[i][wr_ptr_q[i]] <= {fu_tag[i], fu_data[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      write_en_q   <= '0;
      write_idx_q  <= '0;
      write_data_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      write_en_q   <= write_en_d;
      write_idx_q  <= write_idx_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_idx  = write_idx_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (NUM_FU=4, DEPTH=2, N_WR=2).
module tb_wb_write_arbiter;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 flush = 1'b0;
  logic [3:0]           fu_valid = '0;
  logic [3:0][7:0]      fu_tag = '0;
  logic [3:0][31:0]     fu_data = '0;
  logic [3:0]           fu_ready;
  logic [1:0]           write_en;
  logic [1:0][7:0]      write_idx;
  logic [1:0][31:0]     write_data;

  int passed = 0;
  int checks = 0;

  wb_write_arbiter #(
    .NUM_FU (4),
    .DEPTH  (2),
    .N_WR   (2),
    .TAG_W  (8),
    .DATA_W (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_tag     (fu_tag),
    .fu_data    (fu_data),
    .fu_ready   (fu_ready),
    .write_en   (write_en),
    .write_idx  (write_idx),
    .write_data (write_data)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] data_of(input logic [7:0] t);
    return {16'hD00D, t, ~t};
  endfunction

  logic [7:0] sb [$];
  logic [5:0] seq [4];
  int         dbl;
  bit         saw_bp;

  initial begin
    // Reset state
    tick;
    tick;
    chk("rst_en", 64'(write_en), 64'h0);
    chk("rst_idx", 64'(write_idx), 64'h0);
    reset = 1'b0;
    tick;
    chk("rst_ready", 64'(fu_ready), 64'hF);
    chk("rst_en_after", 64'(write_en), 64'h0);

    // Single write from FU1: c+2 latency, one cycle only
    fu_valid = 4'b0010; fu_tag[1] = 8'd5; fu_data[1] = 32'hABCD;
    tick;
    fu_valid = '0;
    chk("single_c1_en", 64'(write_en), 64'h0);
    tick;
    chk("single_en", 64'(write_en), 64'h1);
    chk("single_idx", 64'(write_idx[0]), 64'd5);
    chk("single_data", 64'(write_data[0]), 64'hABCD);
    tick;
    chk("single_c3_en", 64'(write_en), 64'h0);

    // Flush to bring rr_ptr back to 0
    flush = 1'b1;
    tick;
    flush = 1'b0;

    // Round robin: all four FUs in one cycle
    fu_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      fu_tag[i] = 8'(10 + i); fu_data[i] = 32'(100 + i);
    end
    tick;
    fu_valid = '0;
    tick;
    chk("rr1_en", 64'(write_en), 64'h3);
    chk("rr1_idx0", 64'(write_idx[0]), 64'd10);
    chk("rr1_idx1", 64'(write_idx[1]), 64'd11);
    chk("rr1_data1", 64'(write_data[1]), 64'd101);
    tick;
    chk("rr2_en", 64'(write_en), 64'h3);
    chk("rr2_idx0", 64'(write_idx[0]), 64'd12);
    chk("rr2_idx1", 64'(write_idx[1]), 64'd13);
    tick;
    chk("rr3_en", 64'(write_en), 64'h0);
    // rr_ptr back at 0: FU0 must land on port 0 ahead of FU3
    fu_valid = 4'b1001; fu_tag[0] = 8'd20; fu_tag[3] = 8'd23;
    tick;
    fu_valid = '0;
    tick;
    chk("rr_wrap_en", 64'(write_en), 64'h3);
    chk("rr_wrap_idx0", 64'(write_idx[0]), 64'd20);
    chk("rr_wrap_idx1", 64'(write_idx[1]), 64'd23);
    tick;

    // Asynchronous reset mid-traffic
    fu_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      fu_tag[i] = 8'(50 + i); fu_data[i] = 32'(500 + i);
    end
    tick;
    fu_valid = '0;
    tick;
    chk("arst_pre_en", 64'(write_en), 64'h3);
    #2 reset = 1'b1;
    #1;
    chk("arst_en", 64'(write_en), 64'h0);
    chk("arst_idx", 64'(write_idx), 64'h0);
    chk("arst_data", 64'(write_data), 64'h0);
    tick;
    reset = 1'b0;
    tick;
    chk("arst_ready", 64'(fu_ready), 64'hF);
    for (int c = 0; c < 3; c++) begin
      chk("arst_no_stale", 64'(write_en), 64'h0);
      tick;
    end

    // Flush with five entries queued and FU2 offering in the flush cycle
    fu_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      fu_tag[i] = 8'(30 + i); fu_data[i] = 32'(300 + i);
    end
    tick;
    fu_valid = 4'b1011;
    fu_tag[0] = 8'd34; fu_tag[1] = 8'd35; fu_tag[3] = 8'd37;
    tick;
    chk("fl_pre_en", 64'(write_en), 64'h3);
    chk("fl_pre_idx0", 64'(write_idx[0]), 64'd30);
    chk("fl_pre_idx1", 64'(write_idx[1]), 64'd31);
    flush = 1'b1;
    fu_valid = 4'b0100; fu_tag[2] = 8'd40;
    tick;
    flush = 1'b0;
    fu_valid = '0;
    chk("fl_en", 64'(write_en), 64'h0);
    chk("fl_idx", 64'(write_idx), 64'h0);
    chk("fl_ready", 64'(fu_ready), 64'hF);
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("fl_no_write", 64'(write_en), 64'h0);
    end

    // Backpressure: every FU offers continuously for 20 cycles
    for (int i = 0; i < 4; i++) seq[i] = 6'd1;
    dbl = 0;
    saw_bp = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        fu_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
          fu_tag[i]  = {2'(i), seq[i]};
          fu_data[i] = data_of(fu_tag[i]);
        end
      end else begin
        fu_valid = '0;
      end
      for (int i = 0; i < 4; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          sb.push_back(fu_tag[i]);
          seq[i] = seq[i] + 6'd1;
        end
      end
      if (fu_valid != 4'h0 && fu_ready != 4'hF) saw_bp = 1'b1;
      tick;
      if (c >= 1 && c < 20 && write_en == 2'b11) dbl++;
      for (int p = 0; p < 2; p++) begin
        if (write_en[p]) begin
          int j;
          j = -1;
          for (int s = 0; s < sb.size(); s++) begin
            if (j < 0 && sb[s][7:6] == write_idx[p][7:6]) j = s;
          end
          if (j < 0) begin
            checks++;
            $error("FAIL bp_unexpected: observed tag %0h expected none", write_idx[p]);
          end else begin
            chk("bp_order", 64'(write_idx[p]), 64'(sb[j]));
            chk("bp_data", 64'(write_data[p]), 64'(data_of(write_idx[p])));
            sb.delete(j);
          end
        end
      end
    end
    chk("bp_saw_backpressure", 64'(saw_bp), 64'h1);
    chk("bp_dual_writes", 64'(dbl), 64'd19);
    chk("bp_all_written", 64'(sb.size()), 64'd0);

    // Zero tag handling
    flush = 1'b1;
    tick;
    flush = 1'b0;
    fu_valid = 4'b0011;
    fu_tag[0] = 8'd0; fu_data[0] = 32'h0;
    fu_tag[1] = 8'd7; fu_data[1] = 32'h70;
    tick;
    fu_valid = '0;
    tick;
`ifdef WB_DROP_ZERO_TAG_EN
    chk("zt_en", 64'(write_en), 64'h1);
    chk("zt_idx0", 64'(write_idx[0]), 64'd7);
`else
    chk("zt_en", 64'(write_en), 64'h3);
    chk("zt_idx0", 64'(write_idx[0]), 64'd0);
    chk("zt_idx1", 64'(write_idx[1]), 64'd7);
`endif
    tick;
    chk("zt_after_en", 64'(write_en), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
